// File: rtl/tlk2711_wr_cmd_arb_if.sv
// Signal bundle between the rx links, the write-command arbiter and the shared tlk2711 DMA write channel.
// slave is the arbiter's view; master is the view of whatever drives the links and DMA.
interface tlk2711_wr_cmd_arb_if #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DLEN_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WBYTE_WIDTH     = 2,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_CH-1:0]             i_ch_cmd_req;
    logic [NUM_CH*CMD_W-1:0]       i_ch_cmd_data;
    logic [NUM_CH-1:0]             o_ch_cmd_ack;
    logic [NUM_CH-1:0]             i_ch_wr_valid;
    logic [NUM_CH*WBYTE_WIDTH-1:0] i_ch_wr_keep;
    logic [NUM_CH*DATA_WIDTH-1:0]  i_ch_wr_data;
    logic [NUM_CH-1:0]             o_ch_wr_ready;
    logic [NUM_CH-1:0]             o_ch_wr_finish;
    logic                          o_wr_cmd_req;
    logic [CMD_W-1:0]              o_wr_cmd_data;
    logic                          i_wr_cmd_ack;
    logic                          o_dma_wr_valid;
    logic [WBYTE_WIDTH-1:0]        o_dma_wr_keep;
    logic [DATA_WIDTH-1:0]         o_dma_wr_data;
    logic                          i_dma_wr_ready;
    logic                          i_wr_finish;
    logic [OUT_W-1:0]              o_outstanding;
    logic                          o_busy;

    modport slave (
        input  i_ch_cmd_req, i_ch_cmd_data, i_ch_wr_valid, i_ch_wr_keep, i_ch_wr_data,
               i_wr_cmd_ack, i_dma_wr_ready, i_wr_finish,
        output o_ch_cmd_ack, o_ch_wr_ready, o_ch_wr_finish, o_wr_cmd_req, o_wr_cmd_data,
               o_dma_wr_valid, o_dma_wr_keep, o_dma_wr_data, o_outstanding, o_busy
    );

    modport master (
        output i_ch_cmd_req, i_ch_cmd_data, i_ch_wr_valid, i_ch_wr_keep, i_ch_wr_data,
               i_wr_cmd_ack, i_dma_wr_ready, i_wr_finish,
        input  o_ch_cmd_ack, o_ch_wr_ready, o_ch_wr_finish, o_wr_cmd_req, o_wr_cmd_data,
               o_dma_wr_valid, o_dma_wr_keep, o_dma_wr_data, o_outstanding, o_busy
    );
endinterface

// File: rtl/tlk2711_wr_cmd_arb.sv
// Round-robin arbiter sharing one tlk2711 DMA write channel among NUM_CH rx links.
// An in-order owner FIFO steers write data to the DMA and finish pulses back to the links.
module tlk2711_wr_cmd_arb #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DLEN_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WBYTE_WIDTH     = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_soft_rst,
    tlk2711_wr_cmd_arb_if.slave bus
);
    localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int PTR_W = IDX_W + 1;
    localparam int WB_SH = $clog2(WBYTE_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACKD} state_t;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DLEN_WIDTH-1:0] beats;
    } entry_t;

    // len rounded up to whole beats; a zero-length command still moves one beat
    function automatic logic [DLEN_WIDTH-1:0] beats_of(input logic [DLEN_WIDTH-1:0] len);
        logic [DLEN_WIDTH-1:0] rem;
        rem = len & DLEN_WIDTH'(WBYTE_WIDTH - 1);
        if (len == '0) return DLEN_WIDTH'(1);
        return (len >> WB_SH) + DLEN_WIDTH'(rem != '0);
    endfunction

    logic                  srst;
    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d, gnt_q, gnt_d, sel_ch;
    logic                  sel_found;
    logic                  req_q, req_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic [NUM_CH-1:0]     ack_q, ack_d, fin_q;
    logic                  push, pop, full, has_owner, beat_fire, last_beat;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, dp, outstanding;
    logic [DLEN_WIDTH-1:0] beat_cnt;
    entry_t                fifo [MAX_OUTSTANDING];
    entry_t                own_e;

    assign srst        = rst | i_soft_rst;
    assign outstanding = wr_ptr - rd_ptr;
    assign full        = (outstanding == PTR_W'(MAX_OUTSTANDING));
    assign pop         = bus.i_wr_finish & (wr_ptr != rd_ptr);

    // first requester at or after rr_q, wrapping
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!sel_found && bus.i_ch_cmd_req[idx]) begin
                sel_found = 1'b1;
                sel_ch    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        cmd_d   = cmd_q;
        ack_d   = '0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found && !full) begin
                    gnt_d   = sel_ch;
                    cmd_d   = bus.i_ch_cmd_data[sel_ch*CMD_W +: CMD_W];
                    req_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.i_wr_cmd_ack) begin
                    req_d        = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    push         = 1'b1;
                    rr_d         = (gnt_q == ID_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
                    state_d      = S_ACKD;
                end
            end
            // the link still shows its request while the ack pulse is out; skip one cycle
            S_ACKD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gnt_q    <= '0;
            req_q    <= 1'b0;
            cmd_q    <= '0;
            ack_q    <= '0;
            fin_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dp       <= '0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
            fin_q   <= '0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                fin_q[fifo[rd_ptr[IDX_W-1:0]].id] <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (beat_fire) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    dp       <= dp + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[IDX_W-1:0]] <= '{id: gnt_q, beats: beats_of(cmd_q[CMD_W-1:ADDR_WIDTH])};
    end

    // data owner is the oldest entry whose beats are not all transferred
    assign has_owner = (dp != wr_ptr);
    assign own_e     = fifo[dp[IDX_W-1:0]];
    assign beat_fire = bus.o_dma_wr_valid & bus.i_dma_wr_ready;
    assign last_beat = (beat_cnt == own_e.beats - 1'b1);

    always_comb begin
        bus.o_dma_wr_valid = 1'b0;
        bus.o_dma_wr_keep  = '0;
        bus.o_dma_wr_data  = '0;
        bus.o_ch_wr_ready  = '0;
        if (has_owner) begin
            bus.o_dma_wr_valid          = bus.i_ch_wr_valid[own_e.id];
            bus.o_dma_wr_keep           = bus.i_ch_wr_keep[own_e.id*WBYTE_WIDTH +: WBYTE_WIDTH];
            bus.o_dma_wr_data           = bus.i_ch_wr_data[own_e.id*DATA_WIDTH +: DATA_WIDTH];
            bus.o_ch_wr_ready[own_e.id] = bus.i_dma_wr_ready;
        end
    end

    assign bus.o_wr_cmd_req   = req_q;
    assign bus.o_wr_cmd_data  = cmd_q;
    assign bus.o_ch_cmd_ack   = ack_q;
    assign bus.o_ch_wr_finish = fin_q;
    assign bus.o_outstanding  = outstanding;
    assign bus.o_busy         = (outstanding != '0) | (state_q != S_IDLE);
endmodule
